shift_sequencer: RTL

- Command sequencer sitting directly upstream of the 8-bit mode-driven shift register; it is the only driver of that register's mode, parallel-data and fill-bit inputs.
- Accepts one command per valid/ready handshake: an operation code, load data, fill bit and repeat count. It then applies the operation to the shift register for exactly `count` consecutive cycles.
- The shift register has no hold mode, so when idle the sequencer holds it by reloading its own output (load mode, data = fed-back register value).

---
 rtl/shifter_pkg.sv | 19 +
 rtl/shift_sequencer_counter.sv | 30 +++
 rtl/shift_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared mode codes for the 8-bit mode-driven shift register and the
// sequencer state encoding.
package shifter_pkg;

  localparam logic [2:0] MODE_CLR  = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_LSR  = 3'b010;
  localparam logic [2:0] MODE_LSL  = 3'b011;
  localparam logic [2:0] MODE_ASR  = 3'b100;
  localparam logic [2:0] MODE_FSR  = 3'b101;
  localparam logic [2:0] MODE_ROR  = 3'b110;
  localparam logic [2:0] MODE_ROL  = 3'b111;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/shift_sequencer_counter.sv
// Repeat counter for the sequencer: load, decrement toward zero, flush,
// and a flag marking the final cycle of a run.
module seq_down_counter #(
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic               flush,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] cnt,
  output logic               last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == COUNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer driving an 8-bit mode-driven shift register.
// Optional SHIFT_SEQ_B2B_EN accepts the next command on a run's last cycle.
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [7:0]         cmd_data,
  input  logic               cmd_fill,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               cmd_flush,
  input  logic [7:0]         sh_q,
  output logic [2:0]         sh_mode,
  output logic [7:0]         sh_in,
  output logic               sh_left,
  output logic               busy,
  output logic               done
);

  seq_state_t         state;
  logic [2:0]         op_q;
  logic [7:0]         data_q;
  logic               fill_q;
  logic [COUNT_W-1:0] cnt;
  logic               last;
  logic               accept;

  always_comb begin
    cmd_ready = 1'b0;
    if (!cmd_flush) begin
      if (state == SEQ_IDLE) begin
        cmd_ready = 1'b1;
      end
`ifdef SHIFT_SEQ_B2B_EN
      else if (last) begin
        cmd_ready = 1'b1;
      end
`endif
    end
  end

  assign accept  = cmd_valid & cmd_ready;
  // Idle holds the register by reloading its own output.
  assign sh_in   = (state == SEQ_RUN) ? data_q : sh_q;
  assign sh_left = fill_q;

  seq_down_counter #(.COUNT_W(COUNT_W)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .dec      (state == SEQ_RUN),
    .flush    (cmd_flush),
    .load_val (cmd_count),
    .cnt      (cnt),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SEQ_IDLE;
      op_q    <= MODE_LOAD;
      data_q  <= '0;
      fill_q  <= 1'b0;
      sh_mode <= MODE_LOAD;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_flush) begin
        state   <= SEQ_IDLE;
        sh_mode <= MODE_LOAD;
        busy    <= 1'b0;
      end else begin
        if ((state == SEQ_RUN) && last) begin
          done    <= 1'b1;
          state   <= SEQ_IDLE;
          sh_mode <= MODE_LOAD;
          busy    <= 1'b0;
        end
        // A new accept overrides the return to idle when runs chain.
        if (accept) begin
          op_q   <= cmd_op;
          data_q <= cmd_data;
          fill_q <= cmd_fill;
          if (cmd_count != '0) begin
            state   <= SEQ_RUN;
            sh_mode <= cmd_op;
            busy    <= 1'b1;
          end else begin
            done <= 1'b1;
          end
        end
      end
    end
  end

endmodule
